uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter with a character FIFO in front of the shifter.
- Supports 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits, all selected at run time.
- Runs entirely on one clock; bit timing comes from a one-cycle baud_tick enable generated by the baud-rate block.
- Sits between the register-file write port (data register address decode done upstream) and the txd pin.

Parameters:
- FIFO_DEPTH, 4, number of queued characters; power of two, minimum 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the fifo_level output.

Ports:
- clk        input   1      system clock
- rst        input   1      asynchronous, active-high reset
- baud_tick  input   1      one-cycle pulse per bit period
- tx_en      input   1      transmitter enable
- char_size  input   3      000=5, 001=6, 010=7, 011=8, 111=9 data bits; 100–110 treated as 8
- parity_mode input  2      00 none, 01 reserved (none), 10 even, 11 odd
- stop2      input   1      0 = one stop bit, 1 = two stop bits
- wr_en      input   1      push wr_data into the FIFO
- wr_data    input   9      character; bit 8 is used only in 9-bit mode
- wr_ready   output  1      FIFO not full (data-register-empty flag)
- txc        output  1      transmit-complete flag, sticky
- txc_clr    input   1      clears txc
- busy       output  1      a frame is in progress
- fifo_level output  LVL_W  number of characters queued
- txd        output  1      serial out, registered, idle high

Behaviour:
- Reset values: txd=1, wr_ready=1, txc=1, busy=0, fifo_level=0, state=IDLE, FIFO empty. Reset asserted mid-frame aborts the frame and drives txd=1 immediately.
- FIFO
  - A push is accepted when wr_en=1 and the FIFO is not full. A push while full is dropped silently; contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle are both honoured and the level is unchanged.
  - A push into an empty FIFO is not popped in the same cycle.
- State machine: IDLE, START, DATA, PARITY, STOP. All transitions occur only on cycles where baud_tick=1.
- IDLE
  - txd=1.
  - On baud_tick with tx_en=1 and the FIFO non-empty: pop the head into the shift register, latch char_size, parity_mode and stop2 for the whole frame, and go to START.
- START: txd=0 for one bit period, then go to DATA.
- DATA
  - Data bits are sent LSB first; N = latched size.
  - A 4-bit counter runs 0..N-1 and clears on exit.
  - Exit to PARITY if parity is enabled, otherwise to STOP.
- PARITY: send the even parity bit (XOR of the N data bits) or its complement for odd parity.
- STOP
  - txd=1 for one bit period, or two when stop2 is set.
  - On the final stop tick: if tx_en=1 and the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- txd is registered and changes in the cycle after the baud_tick that selects the new bit. Each bit is held for exactly one tick-to-tick period.
- busy=1 in any state other than IDLE.
- txc
  - Set on the final stop tick when the FIFO is empty.
  - Cleared by txc_clr=1 or by an accepted push.
  - If set and clear occur in the same cycle, set wins.
- tx_en deasserted mid-frame: the current frame completes, then the block idles. Queued characters are held until tx_en returns.
- Configuration changes mid-frame take effect from the next frame only.

Optional Feature:
UART_TX_BREAK_EN
- With the macro defined: a send_break input port is added. While send_break=1, txd is forced to 0 after the current frame ends, and no characters are popped. txd returns to 1 on the first baud_tick after send_break falls, after which normal operation resumes.
- Without the macro: the port does not exist and behaviour is exactly as specified above.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - char_size codes and a function mapping a code to a bit count;
  - parity_mode codes.
- One sub-module, uart_sync_fifo: a parametrised FIFO (WIDTH=9, DEPTH) with push/pop/full/empty/level. The top level is the FSM plus the shifter.

Test Plan:
- 8N1, single write 0x0A5, baud_tick every 16 clk → txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clk long. txc rises on the stop tick; wr_ready stays 1.
- 7E2, write 0x035 → start, 1,0,1,0,1,1,0, parity 0, stop 1,1. Same setup with odd parity → parity bit 1.
- 9-bit odd parity, write 0x1FF → nine 1s, parity 0, stop 1.
- FIFO_DEPTH=4, tx_en=0, write 5 characters → fifo_level=4, wr_ready=0, 5th dropped. Raise tx_en → four back-to-back frames with no idle bit between them; txc set only after the 4th.
- Assert rst during DATA bit 3 → txd=1 within the same cycle, fifo_level=0, state IDLE. After release, a new write transmits correctly.
- txc_clr and the final stop tick in the same cycle → txc=1. A later accepted push clears txc.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, character
// size codes with their bit-count mapping, and parity mode codes.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [2:0] CS_5 = 3'b000;
   localparam logic [2:0] CS_6 = 3'b001;
   localparam logic [2:0] CS_7 = 3'b010;
   localparam logic [2:0] CS_8 = 3'b011;
   localparam logic [2:0] CS_9 = 3'b111;

   localparam logic [1:0] PM_NONE = 2'b00;
   localparam logic [1:0] PM_RSVD = 2'b01;
   localparam logic [1:0] PM_EVEN = 2'b10;
   localparam logic [1:0] PM_ODD  = 2'b11;

   // Codes 100..110 are unassigned and fall back to 8 data bits.
   function automatic logic [3:0] char_bits(input logic [2:0] code);
      case (code)
         CS_5:    return 4'd5;
         CS_6:    return 4'd6;
         CS_7:    return 4'd7;
         CS_9:    return 4'd9;
         default: return 4'd8;
      endcase
   endfunction

   // Keeps the low n bits of a character, clearing the rest.
   function automatic logic [8:0] char_mask(input logic [3:0] n);
      logic [8:0] m;
      for (int i = 0; i < 9; i++) m[i] = (i < int'(n));
      return m;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO holding queued characters ahead of the shifter.
// Ports: clk, rst (async active-high), push/din write side, pop/dout read
// side (dout shows the head combinationally), full, empty, level.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a character FIFO in front of the shifter.
// 5-9 data bits, none/even/odd parity, 1 or 2 stop bits, chosen at run time
// and latched per frame. Bit timing comes from the one-cycle baud_tick.
// Ports: clk, rst (async active-high), baud_tick, tx_en, char_size,
// parity_mode, stop2, wr_en/wr_data (push), wr_ready (not full),
// txc/txc_clr (sticky transmit complete), busy, fifo_level, txd (registered).
// Optional macro UART_TX_BREAK_EN adds send_break: holds txd low between
// frames while asserted and suppresses popping.
//
// state  | meaning
// IDLE   | line high, waiting for tick with tx_en and queued data
// START  | start bit (0)
// DATA   | data bits, LSB first, bit_cnt 0..N-1
// PARITY | parity bit
// STOP   | stop bit(s), stop_cnt selects the second one
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             baud_tick,
   input  logic             tx_en,
   input  logic [2:0]       char_size,
   input  logic [1:0]       parity_mode,
   input  logic             stop2,
`ifdef UART_TX_BREAK_EN
   input  logic             send_break,
`endif
   input  logic             wr_en,
   input  logic [8:0]       wr_data,
   output logic             wr_ready,
   output logic             txc,
   input  logic             txc_clr,
   output logic             busy,
   output logic [LVL_W-1:0] fifo_level,
   output logic             txd
);

   state_t     state;
   logic [8:0] shift;
   logic [3:0] bit_cnt, n_bits;
   logic       par_en, par_bit, stop2_l, stop_cnt;

   logic [8:0] fifo_dout, frame_data;
   logic [3:0] frame_bits;
   logic       fifo_full, fifo_empty;
   logic       push_ok, last_stop, at_frame_gap, pop, txc_set;
   logic       brk_block, idle_txd;

   uart_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .din   (wr_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

`ifdef UART_TX_BREAK_EN
   // brk remembers that the previous gap tick was a break so the first tick
   // after send_break falls only restores the line instead of starting a frame.
   logic brk;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         brk <= 1'b0;
      else if (baud_tick && at_frame_gap) brk <= send_break;
   end
   assign brk_block = send_break || brk;
   assign idle_txd  = !send_break;
`else
   assign brk_block = 1'b0;
   assign idle_txd  = 1'b1;
`endif

   assign wr_ready     = !fifo_full;
   assign push_ok      = wr_en && !fifo_full;
   assign last_stop    = !stop2_l || stop_cnt;
   assign at_frame_gap = (state == IDLE) || (state == STOP && last_stop);
   assign pop          = baud_tick && at_frame_gap && tx_en && !fifo_empty && !brk_block;
   assign txc_set      = baud_tick && (state == STOP) && last_stop && fifo_empty;

   assign frame_bits = char_bits(char_size);
   assign frame_data = fifo_dout & char_mask(frame_bits);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         txd      <= 1'b1;
         busy     <= 1'b0;
         txc      <= 1'b1;
         shift    <= '0;
         bit_cnt  <= '0;
         n_bits   <= 4'd8;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         stop2_l  <= 1'b0;
         stop_cnt <= 1'b0;
      end else begin
         if (txc_set)                 txc <= 1'b1;
         else if (txc_clr || push_ok) txc <= 1'b0;

         if (pop) begin
            // Frame configuration is captured here and held until the next pop.
            state    <= START;
            busy     <= 1'b1;
            txd      <= 1'b0;
            shift    <= frame_data;
            n_bits   <= frame_bits;
            par_en   <= parity_mode[1];
            par_bit  <= (^frame_data) ^ (parity_mode == PM_ODD);
            stop2_l  <= stop2;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
         end else if (baud_tick) begin
            case (state)
               IDLE: txd <= idle_txd;
               START: begin
                  state <= DATA;
                  txd   <= shift[0];
                  shift <= shift >> 1;
               end
               DATA: begin
                  if (bit_cnt == n_bits - 4'd1) begin
                     bit_cnt <= '0;
                     if (par_en) begin
                        state <= PARITY;
                        txd   <= par_bit;
                     end else begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     txd     <= shift[0];
                     shift   <= shift >> 1;
                  end
               end
               PARITY: begin
                  state <= STOP;
                  txd   <= 1'b1;
               end
               STOP: begin
                  if (!last_stop) begin
                     stop_cnt <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     stop_cnt <= 1'b0;
                     txd      <= idle_txd;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  txd   <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: drives characters and configurations, samples
// txd once per bit period and decodes frames like a receiver, comparing them
// with the queue of characters that were accepted.
module tb_uart_tx_fifo;

   localparam int BAUD  = 16;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0, rst = 1'b1, baud_tick = 1'b0, tx_en = 1'b0;
   logic [2:0]    char_size = 3'b011;
   logic [1:0]    parity_mode = 2'b00;
   logic          stop2 = 1'b0, wr_en = 1'b0, txc_clr = 1'b0;
   logic [8:0]    wr_data = '0;
   logic          wr_ready, txc, busy, txd;
   logic [LW-1:0] fifo_level;

   uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
      .char_size(char_size), .parity_mode(parity_mode), .stop2(stop2),
      .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready), .txc(txc),
      .txc_clr(txc_clr), .busy(busy), .fifo_level(fifo_level), .txd(txd)
   );

   always #5 clk = ~clk;

   int         checks = 0, failures = 0;
   int         cnt = 0;
   int         txc_rises = 0;
   logic       prev_txc = 1'b1;
   bit         clr_mode = 1'b0;
   logic       cap[$];
   logic [8:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; at the falling edge update the baud pulse and sample txd mid-bit.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cnt = (cnt + 1) % BAUD;
      baud_tick = (cnt == 0);
      if (cnt == BAUD / 2) cap.push_back(txd);
      if (txc && !prev_txc) txc_rises++;
      prev_txc = txc;
      txc_clr = clr_mode && baud_tick && busy;
   endtask

   task automatic push(input logic [8:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
   endtask

   task automatic run_until_idle();
      bit seen = 0;
      for (int i = 0; i < 20000; i++) begin
         step();
         if (busy) seen = 1;
         if (seen && !busy && fifo_level == 0) break;
      end
      check("run_done", {31'd0, seen && !busy}, 32'd1);
      repeat (BAUD * 2) step();
   endtask

   function automatic int cs_bits(input logic [2:0] code);
      case (code)
         3'd0: return 5;
         3'd1: return 6;
         3'd2: return 7;
         3'd7: return 9;
         default: return 8;
      endcase
   endfunction

   function automatic logic get_bit(input int i);
      return (i < cap.size()) ? cap[i] : 1'bx;
   endfunction

   // Receiver-style decode of the captured line against exp_q.
   task automatic decode(input int nbits, input bit pen, input bit podd, input bit s2, input bit b2b);
      int idx = 0;
      for (int f = 0; f < exp_q.size(); f++) begin
         int gap = 0;
         logic [8:0] d = '0;
         int ones = 0;
         int expd;
         while (idx < cap.size() && cap[idx] === 1'b1) begin
            gap++;
            idx++;
         end
         if (f > 0 && b2b) check("b2b_gap", gap, 0);
         check("start_bit", {31'd0, get_bit(idx)}, 0);
         idx++;
         for (int i = 0; i < nbits; i++) begin
            d[i] = get_bit(idx);
            idx++;
         end
         expd = int'(exp_q[f]) % (1 << nbits);
         check("data", {23'd0, d}, expd);
         for (int i = 0; i < nbits; i++) ones += (expd >> i) & 1;
         if (pen) begin
            check("parity", {31'd0, get_bit(idx)}, (ones % 2) ^ int'(podd));
            idx++;
         end
         for (int s = 0; s < (s2 ? 2 : 1); s++) begin
            check("stop_bit", {31'd0, get_bit(idx)}, 1);
            idx++;
         end
      end
      begin
         int tail = 0;
         for (int i = idx; i < cap.size(); i++) if (cap[i] === 1'b1) tail++;
         check("idle_tail", tail, cap.size() - idx);
      end
      cap.delete();
      exp_q.delete();
   endtask

   initial begin
      repeat (2) step();
      check("rst_txd", {31'd0, txd}, 1);
      check("rst_wr_ready", {31'd0, wr_ready}, 1);
      check("rst_txc", {31'd0, txc}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_level", fifo_level, 0);
      rst = 1'b0;
      step();

      // 8N1, 0x0A5
      tx_en = 1'b1; char_size = 3'b011; parity_mode = 2'b00; stop2 = 1'b0;
      cap.delete(); txc_rises = 0;
      push(9'h0A5);
      check("t1_txc_cleared", {31'd0, txc}, 0);
      check("t1_wr_ready", {31'd0, wr_ready}, 1);
      run_until_idle();
      decode(8, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_txc", {31'd0, txc}, 1);
      check("t1_txc_rises", txc_rises, 1);

      // 7E2 and 7O2, 0x035
      for (int pm = 2; pm < 4; pm++) begin
         char_size = 3'b010; parity_mode = 2'(pm); stop2 = 1'b1;
         cap.delete();
         push(9'h035);
         run_until_idle();
         decode(7, 1'b1, pm == 3, 1'b1, 1'b0);
      end

      // 9-bit odd parity, 0x1FF
      char_size = 3'b111; parity_mode = 2'b11; stop2 = 1'b0;
      cap.delete();
      push(9'h1FF);
      run_until_idle();
      decode(9, 1'b1, 1'b1, 1'b0, 1'b0);

      // FIFO fill with transmitter disabled, fifth push dropped
      tx_en = 1'b0; char_size = 3'b011; parity_mode = 2'b00; stop2 = 1'b0;
      cap.delete(); txc_rises = 0;
      for (int i = 0; i < 5; i++) push(9'($urandom_range(0, 511)));
      check("full_level", fifo_level, DEPTH);
      check("full_wr_ready", {31'd0, wr_ready}, 0);
      repeat (BAUD * 2) step();
      check("held_level", fifo_level, DEPTH);
      tx_en = 1'b1;
      run_until_idle();
      decode(8, 1'b0, 1'b0, 1'b0, 1'b1);
      check("b2b_txc_rises", txc_rises, 1);
      check("b2b_txc", {31'd0, txc}, 1);

      // Reset during data bit 3 of 0x052
      tx_en = 1'b0;
      push(9'h052);
      push(9'h011);
      tx_en = 1'b1;
      begin
         bit got = 0;
         for (int i = 0; i < BAUD * 4; i++) begin
            step();
            if (busy) begin
               got = 1;
               break;
            end
         end
         check("rst_frame_started", {31'd0, got}, 1);
      end
      repeat (BAUD * 4 + 8) step();
      check("pre_rst_bit3", {31'd0, txd}, 0);
      rst = 1'b1;
      #1;
      check("midrst_txd", {31'd0, txd}, 1);
      check("midrst_level", fifo_level, 0);
      check("midrst_busy", {31'd0, busy}, 0);
      repeat (2) step();
      rst = 1'b0;
      step();
      prev_txc = txc;
      exp_q.delete(); cap.delete();
      push(9'h0C3);
      run_until_idle();
      decode(8, 1'b0, 1'b0, 1'b0, 1'b0);

      // txc_clr coinciding with the final stop tick: set wins
      cap.delete();
      push(9'h0F0);
      clr_mode = 1'b1;
      run_until_idle();
      clr_mode = 1'b0;
      decode(8, 1'b0, 1'b0, 1'b0, 1'b0);
      check("set_wins_txc", {31'd0, txc}, 1);
      tx_en = 1'b0;
      push(9'h011);
      check("push_clears_txc", {31'd0, txc}, 0);
      tx_en = 1'b1;
      cap.delete();
      run_until_idle();
      decode(8, 1'b0, 1'b0, 1'b0, 1'b0);
      check("txc_set_again", {31'd0, txc}, 1);
      txc_clr = 1'b1;
      step();
      check("txc_clr", {31'd0, txc}, 0);

      // Randomized configurations and bursts
      for (int r = 0; r < 6; r++) begin
         int n;
         tx_en = 1'b0;
         char_size   = 3'($urandom_range(0, 7));
         parity_mode = 2'($urandom_range(0, 3));
         stop2       = 1'($urandom_range(0, 1));
         n = $urandom_range(1, DEPTH);
         cap.delete();
         for (int k = 0; k < n; k++) push(9'($urandom_range(0, 511)));
         check("rand_level", fifo_level, n);
         tx_en = 1'b1;
         run_until_idle();
         decode(cs_bits(char_size), parity_mode[1], parity_mode == 2'b11, stop2, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
